// File: rtl/pong_pkg.sv
// Shared encodings and the score-update rule for the Pong match controller.
// Build with PONG_DEUCE_EN defined to get win-by-two scoring.
package pong_pkg;

  localparam logic [2:0] GS_IDLE        = 3'd0;
  localparam logic [2:0] GS_SERVE_WAIT  = 3'd1;
  localparam logic [2:0] GS_PLAY        = 3'd2;
  localparam logic [2:0] GS_POINT_PAUSE = 3'd3;
  localparam logic [2:0] GS_GAME_OVER   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE        = GS_IDLE,
    ST_SERVE_WAIT  = GS_SERVE_WAIT,
    ST_PLAY        = GS_PLAY,
    ST_POINT_PAUSE = GS_POINT_PAUSE,
    ST_GAME_OVER   = GS_GAME_OVER
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Scores are carried at a fixed 16-bit width so one function serves any SCORE_W.
  typedef struct packed {
    logic [15:0] own;
    logic [15:0] opp;
    logic        win;
  } score_res_t;

  function automatic score_res_t score_next(input logic [15:0] own,
                                            input logic [15:0] opp,
                                            input logic [15:0] win_score);
    score_res_t  res;
    logic [15:0] inc;
    inc     = own + 16'd1;
    res.own = (inc > win_score) ? win_score : inc;
    res.opp = opp;
`ifdef PONG_DEUCE_EN
    res.win = (inc >= win_score) && (inc >= opp + 16'd2);
    // Both players sitting on the win score collapses back to deuce.
    if (res.own == win_score && opp == win_score) begin
      res.own = win_score - 16'd1;
      res.opp = win_score - 16'd1;
    end
`else
    res.win = (inc >= win_score);
`endif
    return res;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame-tick counter: vsync rising-edge detect plus a clearable count that
// flags the tick on which the runtime limit is reached.
module pong_frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vsync,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expire
);

  logic             r_vs_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;
  logic [CNT_W:0]   w_cnt_inc;

  assign w_tick    = i_vsync & ~r_vs_d;
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign o_expire  = w_tick && (w_cnt_inc >= {1'b0, i_limit});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_d <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_vs_d <= i_vsync;
      // Saturate so idle states never wrap back into a false terminal count.
      if (i_clr)
        r_cnt <= '0;
      else if (w_tick && r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pong_match_ctl.sv
// Match-level sequencer for Pong: serve/play/pause/game-over, scoring, rally speed.
// Optional macro PONG_DEUCE_EN selects win-by-two scoring.
module pong_match_ctl
  import pong_pkg::*;
#(
  parameter int SCORE_W        = 4,
  parameter int WIN_SCORE      = 7,
  parameter int SERVE_FRAMES   = 60,
  parameter int PAUSE_FRAMES   = 90,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 7,
  parameter int SPEED_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync_in,
  input  logic               mouse_left,
  input  logic               difficulty,
  input  logic               point_p1,
  input  logic               point_p2,
  input  logic               paddle_hit,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [2:0]         game_state,
  output logic               ball_run,
  output logic               serve_left,
  output logic [SPEED_W-1:0] speed_level,
  output logic [1:0]         winner
);

  localparam int FRAME_MAX = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int CNT_W     = $clog2(FRAME_MAX + 1);
  localparam int HIT_W     = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  generate
    if (WIN_SCORE < 2 || WIN_SCORE > (2**SCORE_W) - 1) begin : g_bad_win
      $error("WIN_SCORE must lie in 2 .. 2**SCORE_W-1");
    end
    if (SCORE_W > 15 || MAX_LEVEL > (2**SPEED_W) - 1 || HITS_PER_LEVEL < 1 ||
        SERVE_FRAMES < 1 || PAUSE_FRAMES < 1) begin : g_bad_cfg
      $error("pong_match_ctl parameter out of range");
    end
  endgenerate

  function automatic logic [SPEED_W-1:0] sat_level_inc(input logic [SPEED_W-1:0] lvl);
    if (lvl >= SPEED_W'(MAX_LEVEL))
      return SPEED_W'(MAX_LEVEL);
    return lvl + SPEED_W'(1);
  endfunction

  state_t             r_state, w_nxt_state;
  logic [SCORE_W-1:0] r_score_p1, r_score_p2, w_nxt_score_p1, w_nxt_score_p2;
  logic               r_ball_run, r_serve_left, w_nxt_serve_left;
  logic [SPEED_W-1:0] r_speed, w_nxt_speed;
  logic [1:0]         r_winner, w_nxt_winner;
  logic [HIT_W-1:0]   r_hits, w_nxt_hits;
  logic               r_mouse_d;

  logic               w_press, w_expire, w_clr;
  logic               w_p1_only, w_p2_only, w_both;
  logic [SCORE_W-1:0] w_own, w_opp;
  score_res_t         w_res;
  logic [CNT_W-1:0]   w_limit;

  assign w_press   = mouse_left & ~r_mouse_d;
  assign w_p1_only = point_p1 & ~point_p2;
  assign w_p2_only = point_p2 & ~point_p1;
  assign w_both    = point_p1 & point_p2;
  assign w_own     = w_p1_only ? r_score_p1 : r_score_p2;
  assign w_opp     = w_p1_only ? r_score_p2 : r_score_p1;
  assign w_res     = score_next(16'(w_own), 16'(w_opp), 16'(WIN_SCORE));
  assign w_limit   = (r_state == ST_POINT_PAUSE) ? CNT_W'(PAUSE_FRAMES) : CNT_W'(SERVE_FRAMES);
  // Any state change restarts the frame count, so a coincident tick is dropped.
  assign w_clr     = (w_nxt_state != r_state);

  pong_frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_vsync  (vsync_in),
    .i_clr    (w_clr),
    .i_limit  (w_limit),
    .o_expire (w_expire)
  );

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_score_p1   = r_score_p1;
    w_nxt_score_p2   = r_score_p2;
    w_nxt_serve_left = r_serve_left;
    w_nxt_speed      = r_speed;
    w_nxt_winner     = r_winner;
    w_nxt_hits       = r_hits;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (w_press) begin
          w_nxt_state    = ST_SERVE_WAIT;
          w_nxt_score_p1 = '0;
          w_nxt_score_p2 = '0;
          w_nxt_winner   = WINNER_NONE;
        end
      end
      ST_SERVE_WAIT: begin
        if (w_expire) w_nxt_state = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_both) begin
          w_nxt_state = ST_POINT_PAUSE;
        end else if (w_p1_only || w_p2_only) begin
          if (w_p1_only) begin
            w_nxt_score_p1 = SCORE_W'(w_res.own);
            w_nxt_score_p2 = SCORE_W'(w_res.opp);
          end else begin
            w_nxt_score_p2 = SCORE_W'(w_res.own);
            w_nxt_score_p1 = SCORE_W'(w_res.opp);
          end
          w_nxt_serve_left = w_p2_only;
          if (w_res.win) begin
            w_nxt_state  = ST_GAME_OVER;
            w_nxt_winner = w_p1_only ? WINNER_P1 : WINNER_P2;
          end else begin
            w_nxt_state = ST_POINT_PAUSE;
          end
        end else if (paddle_hit) begin
          if (r_hits >= HIT_W'(HITS_PER_LEVEL - 1)) begin
            w_nxt_hits  = '0;
            w_nxt_speed = sat_level_inc(r_speed);
          end else begin
            w_nxt_hits = r_hits + HIT_W'(1);
          end
        end
      end
      ST_POINT_PAUSE: begin
        if (w_expire) w_nxt_state = ST_SERVE_WAIT;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    // Every serve restarts the rally at the selected base speed.
    if (w_nxt_state == ST_SERVE_WAIT) begin
      w_nxt_speed = SPEED_W'(difficulty);
      w_nxt_hits  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_score_p1   <= '0;
      r_score_p2   <= '0;
      r_ball_run   <= 1'b0;
      r_serve_left <= 1'b1;
      r_speed      <= '0;
      r_winner     <= WINNER_NONE;
      r_hits       <= '0;
      r_mouse_d    <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_score_p1   <= w_nxt_score_p1;
      r_score_p2   <= w_nxt_score_p2;
      r_ball_run   <= (w_nxt_state == ST_PLAY);
      r_serve_left <= w_nxt_serve_left;
      r_speed      <= w_nxt_speed;
      r_winner     <= w_nxt_winner;
      r_hits       <= w_nxt_hits;
      r_mouse_d    <= mouse_left;
    end
  end

  assign score_p1    = r_score_p1;
  assign score_p2    = r_score_p2;
  assign game_state  = r_state;
  assign ball_run    = r_ball_run;
  assign serve_left  = r_serve_left;
  assign speed_level = r_speed;
  assign winner      = r_winner;

endmodule

// File: tb/tb_pong_match_ctl.sv
// Directed bench for pong_match_ctl: a vector table for the main match flow,
// then hand-written sequences for match end, restart and asynchronous reset.
module tb_pong_match_ctl;

  typedef enum int {OP_NOP, OP_PRESS, OP_TICK, OP_P1, OP_P2, OP_BOTH, OP_HIT} op_e;

  typedef struct {
    op_e        op;
    logic       diff;
    logic [2:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       br;
    logic       sl;
    logic [2:0] spd;
    logic [1:0] win;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vsync_in = 1'b0, mouse_left = 1'b0, difficulty = 1'b0;
  logic       point_p1 = 1'b0, point_p2 = 1'b0, paddle_hit = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic [2:0] game_state, speed_level;
  logic       ball_run, serve_left;
  logic [1:0] winner;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pong_match_ctl #(
    .SCORE_W(4), .WIN_SCORE(3), .SERVE_FRAMES(2), .PAUSE_FRAMES(2),
    .HITS_PER_LEVEL(2), .MAX_LEVEL(3), .SPEED_W(3)
  ) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .mouse_left(mouse_left),
    .difficulty(difficulty), .point_p1(point_p1), .point_p2(point_p2),
    .paddle_hit(paddle_hit), .score_p1(score_p1), .score_p2(score_p2),
    .game_state(game_state), .ball_run(ball_run), .serve_left(serve_left),
    .speed_level(speed_level), .winner(winner)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] st, input logic [3:0] s1,
                           input logic [3:0] s2, input logic br, input logic sl,
                           input logic [2:0] spd, input logic [1:0] win);
    chk({tag, ".state"},  8'(game_state),  8'(st));
    chk({tag, ".s1"},     8'(score_p1),    8'(s1));
    chk({tag, ".s2"},     8'(score_p2),    8'(s2));
    chk({tag, ".run"},    8'(ball_run),    8'(br));
    chk({tag, ".serveL"}, 8'(serve_left),  8'(sl));
    chk({tag, ".speed"},  8'(speed_level), 8'(spd));
    chk({tag, ".winner"}, 8'(winner),      8'(win));
  endtask

  // One op = inputs raised on a falling edge, sampled at the next rising edge,
  // dropped on the following falling edge, where outputs are then checked.
  task automatic run_op(input op_e op, input logic diff);
    @(negedge clk);
    difficulty = diff;
    case (op)
      OP_PRESS: mouse_left = 1'b1;
      OP_TICK:  vsync_in   = 1'b1;
      OP_P1:    point_p1   = 1'b1;
      OP_P2:    point_p2   = 1'b1;
      OP_BOTH:  begin point_p1 = 1'b1; point_p2 = 1'b1; end
      OP_HIT:   paddle_hit = 1'b1;
      default: ;
    endcase
    @(negedge clk);
    mouse_left = 1'b0; vsync_in = 1'b0;
    point_p1 = 1'b0; point_p2 = 1'b0; paddle_hit = 1'b0;
  endtask

  function automatic vec_t v(op_e op, logic diff, logic [2:0] st, logic [3:0] s1,
                             logic [3:0] s2, logic br, logic sl, logic [2:0] spd,
                             logic [1:0] win);
    vec_t r;
    r.op = op; r.diff = diff; r.st = st; r.s1 = s1; r.s2 = s2;
    r.br = br; r.sl = sl; r.spd = spd; r.win = win;
    return r;
  endfunction

  logic [3:0] e_s1, e_s2;
  logic [1:0] e_win;
  logic       e_sl;

  initial begin
    //                 op      df st s1 s2 br sl spd win
    vecs.push_back(v(OP_PRESS, 0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(OP_TICK,  0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(OP_TICK,  0, 2, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(OP_P1,    0, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(OP_TICK,  0, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(OP_TICK,  0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(OP_HIT,   0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(OP_TICK,  0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(OP_TICK,  0, 2, 1, 0, 1, 0, 0, 0));
    vecs.push_back(v(OP_BOTH,  0, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(OP_PRESS, 0, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(OP_TICK,  1, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(OP_TICK,  1, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 2, 1, 0, 1, 0, 1, 0));
    vecs.push_back(v(OP_HIT,   1, 2, 1, 0, 1, 0, 1, 0));
    vecs.push_back(v(OP_HIT,   1, 2, 1, 0, 1, 0, 2, 0));
    vecs.push_back(v(OP_HIT,   1, 2, 1, 0, 1, 0, 2, 0));
    vecs.push_back(v(OP_HIT,   1, 2, 1, 0, 1, 0, 3, 0));
    vecs.push_back(v(OP_HIT,   1, 2, 1, 0, 1, 0, 3, 0));
    vecs.push_back(v(OP_HIT,   1, 2, 1, 0, 1, 0, 3, 0));
    vecs.push_back(v(OP_P2,    1, 3, 1, 1, 0, 1, 3, 0));
    vecs.push_back(v(OP_TICK,  1, 3, 1, 1, 0, 1, 3, 0));
    vecs.push_back(v(OP_TICK,  1, 1, 1, 1, 0, 1, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 1, 1, 1, 0, 1, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 2, 1, 1, 1, 1, 1, 0));
    vecs.push_back(v(OP_P2,    1, 3, 1, 2, 0, 1, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 3, 1, 2, 0, 1, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 1, 1, 2, 0, 1, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 1, 1, 2, 0, 1, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 2, 1, 2, 1, 1, 1, 0));
    vecs.push_back(v(OP_P1,    1, 3, 2, 2, 0, 0, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 3, 2, 2, 0, 0, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 1, 2, 2, 0, 0, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 1, 2, 2, 0, 0, 1, 0));
    vecs.push_back(v(OP_TICK,  1, 2, 2, 2, 1, 0, 1, 0));

    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_out("reset", 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].diff);
      check_out($sformatf("v%0d", i), vecs[i].st, vecs[i].s1, vecs[i].s2,
                vecs[i].br, vecs[i].sl, vecs[i].spd, vecs[i].win);
    end

    // Match point from 2/2 in PLAY.
`ifdef PONG_DEUCE_EN
    run_op(OP_P2, 1);
    check_out("adv_p2", 3, 2, 3, 0, 1, 1, 0);
    repeat (4) run_op(OP_TICK, 1);
    check_out("replay1", 2, 2, 3, 1, 1, 1, 0);
    run_op(OP_P1, 1);
    check_out("deuce", 3, 2, 2, 0, 0, 1, 0);
    repeat (4) run_op(OP_TICK, 1);
    run_op(OP_P1, 1);
    check_out("adv_p1", 3, 3, 2, 0, 0, 1, 0);
    repeat (4) run_op(OP_TICK, 1);
    run_op(OP_P1, 1);
    e_s1 = 3; e_s2 = 2; e_win = 2'b01; e_sl = 1'b0;
`else
    run_op(OP_P2, 1);
    e_s1 = 2; e_s2 = 3; e_win = 2'b10; e_sl = 1'b1;
`endif
    check_out("win", 4, e_s1, e_s2, 0, e_sl, 1, e_win);
    run_op(OP_P1, 1);
    run_op(OP_P2, 1);
    run_op(OP_HIT, 1);
    run_op(OP_TICK, 1);
    check_out("over_hold", 4, e_s1, e_s2, 0, e_sl, 1, e_win);
    run_op(OP_PRESS, 1);
    check_out("restart", 1, 0, 0, 0, e_sl, 1, 0);
    run_op(OP_TICK, 1);
    run_op(OP_TICK, 1);
    run_op(OP_HIT, 1);
    run_op(OP_HIT, 1);
    run_op(OP_P1, 1);
    repeat (4) run_op(OP_TICK, 1);
    check_out("pre_rst", 2, 1, 0, 1, 0, 1, 0);

    // Asynchronous reset mid-rally, with a point pulse held across it.
    @(negedge clk);
    #2;
    rst = 1'b0;
    point_p1 = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    point_p1 = 1'b0;
    @(negedge clk);
    check_out("post_rst", 0, 0, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
